// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, stall encodings, divider state codes and the
// decode-to-execute / execute-to-memory bus layouts for the EX stage.
package ex_stage_pkg;

  localparam int unsigned ID_TO_EX_WD  = 159;
  localparam int unsigned EX_TO_MEM_WD = 141;
  localparam int unsigned STALL_BUS    = 6;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned CNT_W        = 6;
  localparam int unsigned ALU_OP_W     = 12;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_RUN  = 2'b01;
  localparam logic [1:0] DIV_DONE = 2'b10;

  // Bit positions inside the one-hot alu_op field
  localparam int unsigned OP_ADD  = 11;
  localparam int unsigned OP_SUB  = 10;
  localparam int unsigned OP_SLT  = 9;
  localparam int unsigned OP_SLTU = 8;
  localparam int unsigned OP_AND  = 7;
  localparam int unsigned OP_NOR  = 6;
  localparam int unsigned OP_OR   = 5;
  localparam int unsigned OP_XOR  = 4;
  localparam int unsigned OP_SLL  = 3;
  localparam int unsigned OP_SRL  = 2;
  localparam int unsigned OP_SRA  = 1;
  localparam int unsigned OP_LUI  = 0;

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         inst;
    logic [ALU_OP_W-1:0] alu_op;
    logic [2:0]          sel_src1;
    logic [3:0]          sel_src2;
    logic                ram_en;
    logic [3:0]          ram_wen;
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic                sel_rf_res;
    logic [31:0]         rdata1;
    logic [31:0]         rdata2;
  } id_ex_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } ex_mem_bus_t;

  // SPECIAL opcode with func 011010 (DIV) or 011011 (DIVU)
  function automatic logic is_div_inst(input logic [31:0] inst);
    return (inst[31:26] == 6'b000000) && (inst[5:1] == 5'b01101);
  endfunction

endpackage

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per cycle.
// IDLE latches operand magnitudes, RUN does 32 subtract steps, DONE presents
// the sign-corrected quotient/remainder until released by hold=0.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] r
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              dz_q, dz_d;

  logic [DATA_W:0]   partial;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quot_next;

  // One restoring step: shift in next dividend bit, try to subtract divisor
  always_comb begin
    partial   = {rem_q, quot_q[DATA_W-1]};
    diff      = partial - {1'b0, dvs_q};
    rem_next  = diff[DATA_W] ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
    quot_next = {quot_q[DATA_W-2:0], ~diff[DATA_W]};
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d = DIV_RUN;
          cnt_d   = '0;
          rem_d   = '0;
          quot_d  = (signed_op && a[DATA_W-1]) ? DATA_W'(-a) : a;
          dvs_d   = (signed_op && b[DATA_W-1]) ? DATA_W'(-b) : b;
          q_neg_d = signed_op & (a[DATA_W-1] ^ b[DATA_W-1]);
          r_neg_d = signed_op & a[DATA_W-1];
          dz_d    = (b == '0);
        end
      end
      DIV_RUN: begin
        rem_d  = rem_next;
        quot_d = quot_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (!hold) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
    end
  end

  // Sign fix-up on the final magnitudes; divide-by-zero forces all-ones quotient
  always_comb begin
    busy = (state_q != DIV_DONE);
    done = (state_q == DIV_DONE);
    q    = '0;
    r    = '0;
    if (done) begin
      q = dz_q ? '1 : (q_neg_q ? DATA_W'(-quot_q) : quot_q);
      r = r_neg_q ? DATA_W'(-rem_q) : rem_q;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage. Registers the ID/EX bus, runs the one-hot ALU,
// issues the data-SRAM request and forwards the write-back target to decode.
// Optional macro EX_DIV_EN builds the iterative DIV/DIVU unit; without it
// DIV/DIVU are no-ops and hilo_we/hi/lo/stallreq_for_ex are tied to 0.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  output logic                    stallreq_for_ex,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    ex_wreg,
  output logic [4:0]              ex_waddr,
  output logic [31:0]             ex_wdata,
  output logic                    ex_opl
);

  id_ex_bus_t  ex_q, ex_d;
  ex_mem_bus_t out_bus;
  logic [31:0] src1, src2, alu_res;
  logic [4:0]  shamt;
  logic        hilo_we;
  logic [31:0] hi, lo;
  logic        unused_bits;

  // ID/EX capture: bubble when ID stops but EX proceeds, else load or hold
  always_comb begin
    ex_d = ex_q;
    if (stall[2] == STOP && stall[3] == NO_STOP) begin
      ex_d = '0;
    end else if (stall[2] == NO_STOP) begin
      ex_d = id_to_ex_bus;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Operand selection; unselected operand reads as zero
  always_comb begin
    src1 = ({32{ex_q.sel_src1[0]}} & ex_q.rdata1)
         | ({32{ex_q.sel_src1[1]}} & ex_q.pc)
         | ({32{ex_q.sel_src1[2]}} & {27'b0, ex_q.inst[10:6]});
    src2 = ({32{ex_q.sel_src2[0]}} & ex_q.rdata2)
         | ({32{ex_q.sel_src2[1]}} & {{16{ex_q.inst[15]}}, ex_q.inst[15:0]})
         | ({32{ex_q.sel_src2[2]}} & 32'd8)
         | ({32{ex_q.sel_src2[3]}} & {16'b0, ex_q.inst[15:0]});
  end

  // One-hot ALU as an AND-OR mux; no op selected yields zero
  always_comb begin
    shamt   = src1[4:0];
    alu_res = ({32{ex_q.alu_op[OP_ADD]}}  & (src1 + src2))
            | ({32{ex_q.alu_op[OP_SUB]}}  & (src1 - src2))
            | ({32{ex_q.alu_op[OP_SLT]}}  & {31'b0, $signed(src1) < $signed(src2)})
            | ({32{ex_q.alu_op[OP_SLTU]}} & {31'b0, src1 < src2})
            | ({32{ex_q.alu_op[OP_AND]}}  & (src1 & src2))
            | ({32{ex_q.alu_op[OP_NOR]}}  & ~(src1 | src2))
            | ({32{ex_q.alu_op[OP_OR]}}   & (src1 | src2))
            | ({32{ex_q.alu_op[OP_XOR]}}  & (src1 ^ src2))
            | ({32{ex_q.alu_op[OP_SLL]}}  & (src2 << shamt))
            | ({32{ex_q.alu_op[OP_SRL]}}  & (src2 >> shamt))
            | ({32{ex_q.alu_op[OP_SRA]}}  & 32'($signed(src2) >>> shamt))
            | ({32{ex_q.alu_op[OP_LUI]}}  & {src2[15:0], 16'b0});
  end

`ifdef EX_DIV_EN
  logic        is_div;
  logic        div_busy, div_done;
  logic [31:0] div_q, div_r;

  assign is_div = is_div_inst(ex_q.inst);

  div_iter u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .signed_op (~ex_q.inst[0]),
    .a         (ex_q.rdata1),
    .b         (ex_q.rdata2),
    .hold      (stall[3] == STOP),
    .busy      (div_busy),
    .done      (div_done),
    .q         (div_q),
    .r         (div_r)
  );

  // Stall until the divider reaches DONE; HI/LO valid only in DONE
  always_comb begin
    stallreq_for_ex = is_div & div_busy;
    hilo_we         = div_done;
    hi              = div_r;
    lo              = div_q;
  end

  assign unused_bits = ^{stall[5:4], stall[1:0], ex_q.inst[25:16]};
`else
  // Divider not built: DIV/DIVU fall through as no-ops
  always_comb begin
    stallreq_for_ex = 1'b0;
    hilo_we         = 1'b0;
    hi              = '0;
    lo              = '0;
  end

  assign unused_bits = ^{stall[5:4], stall[1:0], ex_q.inst[31:16]};
`endif

  // EX/MEM bus, SRAM request and decode forwarding, all from the EX register
  always_comb begin
    out_bus            = '0;
    out_bus.pc         = ex_q.pc;
    out_bus.ram_en     = ex_q.ram_en;
    out_bus.ram_wen    = ex_q.ram_wen;
    out_bus.sel_rf_res = ex_q.sel_rf_res;
    out_bus.rf_we      = ex_q.rf_we;
    out_bus.rf_waddr   = ex_q.rf_waddr;
    out_bus.ex_result  = alu_res;
    out_bus.hilo_we    = hilo_we;
    out_bus.hi         = hi;
    out_bus.lo         = lo;
    ex_to_mem_bus      = out_bus;
    data_sram_en       = ex_q.ram_en;
    data_sram_wen      = ex_q.ram_wen;
    data_sram_addr     = alu_res;
    data_sram_wdata    = ex_q.rdata2;
    ex_wreg            = ex_q.rf_we;
    ex_waddr           = ex_q.rf_waddr;
    ex_wdata           = alu_res;
    ex_opl             = ex_q.sel_rf_res;
  end

endmodule
